// File: rtl/alu_share_pkg.sv
// Shared types for the ALU sharing controller: FSM states, ALU opcodes, ONZ flag indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND   = 3'd2,
    OR    = 3'd3,
    XOR   = 3'd4,
    INC_A = 3'd5,
    MOV_A = 3'd6,
    MOV_B = 3'd7
  } alu_op_t;

  // Bit positions inside the 3-bit ONZ flag vector.
  localparam int ONZ_O = 2;
  localparam int ONZ_N = 1;
  localparam int ONZ_Z = 0;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant among requests, favouring the one not served last.
// Latency: purely combinational.
// Backpressure: none; the caller owns the last-owner pointer and decides when it advances.
// Ports: req[1:0] request vector, last = index of requester served last, grant[1:0] one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // Only a tie needs the pointer: hand it to whoever did not go last.
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters with round-robin grant and valid/ready returns.
// Latency: accept edge k, result captured at k+1, response valid after k+1; one op per 3 cycles peak.
// Backpressure: a low rsp_ready holds RESP indefinitely and blocks new accepts; pending requests wait.
// Ports: req_valid/req_ready + req{0,1}_{op,a,b} command side; rsp_valid/rsp_ready/rsp_result/rsp_onz
//        response side; alu_op/alu_a/alu_b/alu_result/alu_onz wired straight to the ALU; ovf_count.
// Build option: ALU_SHARE_OVF_CNT_EN enables the saturating overflow counter (else ovf_count is 0).
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic [2:0]   rsp_onz,
  output logic [2:0]   alu_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [2:0]   alu_onz,
  input  logic [N-1:0] alu_result,
  output logic [7:0]   ovf_count
);

  state_t     state_q, state_d;
  alu_op_t    op_q;
  logic       owner_q;
  logic       last_q;
  logic [1:0] grant;
  logic       accept;
  logic       rsp_hs;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    accept    = 1'b0;
    rsp_hs    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = grant & req_valid;
        accept    = |(grant & req_valid);
        if (accept) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        // The non-owner's ready bit is deliberately not looked at.
        rsp_hs = rsp_ready[owner_q];
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= ADD;
      alu_a      <= '0;
      alu_b      <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;  // pretend requester 1 went last so requester 0 wins the first tie
      rsp_result <= '0;
      rsp_onz    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant[1];
        op_q    <= grant[1] ? alu_op_t'(req1_op) : alu_op_t'(req0_op);
        alu_a   <= grant[1] ? req1_a : req0_a;
        alu_b   <= grant[1] ? req1_b : req0_b;
      end
      // ALU inputs were registered a full cycle ago, so its outputs are settled here.
      if (state_q == EXEC) begin
        rsp_result <= alu_result;
        rsp_onz    <= alu_onz;
      end
      // Pointer moves only on completion, so a discarded op never affects fairness.
      if (rsp_hs) last_q <= owner_q;
    end
  end

  assign alu_op = op_q;

`ifdef ALU_SHARE_OVF_CNT_EN
  logic [7:0] ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 8'd0;
    end else if (state_q == EXEC && alu_onz[ONZ_O] && ovf_q != 8'hFF) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0] req0_op, req1_op, alu_op, alu_onz, rsp_onz;
  logic [3:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
  logic [7:0] ovf_count;

  always #5 clk = ~clk;

  // Behavioural ALU: flags from true signed arithmetic, result wraps to 4 bits.
  function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, s;
    logic o;
    logic [3:0] r;
    sa = $signed(a);
    sb = $signed(b);
    s  = 0;
    o  = 1'b0;
    r  = a;
    case (op)
      3'd0: begin s = sa + sb; o = (s > 7) || (s < -8); r = s[3:0]; end
      3'd1: begin s = sa - sb; o = (s > 7) || (s < -8); r = s[3:0]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin s = sa + 1; o = (s > 7); r = s[3:0]; end
      3'd6: r = a;
      default: r = b;
    endcase
    return {o, r[3], (r == 4'd0), r};
  endfunction

  assign {alu_onz, alu_result} = alu_fn(alu_op, alu_a, alu_b);

  alu_share_ctrl #(.N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_onz    (rsp_onz),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_onz    (alu_onz),
    .alu_result (alu_result),
    .ovf_count  (ovf_count)
  );

  int   total = 0;
  int   bad = 0;
  cmd_t q0[$];
  cmd_t q1[$];
  cmd_t cur[2];
  bit   presenting[2];
  bit   busy;
  int   owner_m, last_m, acc_cyc, cyc, ovf_m;
  bit   exp_ovf;
  logic [3:0] exp_res;
  logic [2:0] exp_onz;
  int   gaps, rsp_mode, stall_cnt;
  int   grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ovf_exp();
`ifdef ALU_SHARE_OVF_CNT_EN
    return ovf_m;
`else
    return 0;
`endif
  endfunction

  // Who should win given current valids and who was served last.
  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return 1 - last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic drive();
    if (!presenting[0] && q0.size() > 0 && (gaps == 0 || $urandom_range(1, 0) == 1)) begin
      cur[0] = q0.pop_front();
      presenting[0] = 1'b1;
    end
    if (!presenting[1] && q1.size() > 0 && (gaps == 0 || $urandom_range(1, 0) == 1)) begin
      cur[1] = q1.pop_front();
      presenting[1] = 1'b1;
    end
    req_valid = {presenting[1], presenting[0]};
    {req0_op, req0_a, req0_b} = cur[0];
    {req1_op, req1_a, req1_b} = cur[1];
    if (rsp_mode == 1) begin
      rsp_ready = 2'($urandom_range(3, 0));
    end else if (rsp_mode == 2 && busy && cyc >= acc_cyc + 1 && stall_cnt > 0) begin
      rsp_ready = 2'b10;
      stall_cnt--;
    end else begin
      rsp_ready = 2'b11;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, "_rsp_onz"}, 32'(rsp_onz), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_ovf_count"}, 32'(ovf_count), 32'd0);
  endtask

  task automatic model_reset();
    busy = 1'b0;
    last_m = 1;
    ovf_m = 0;
    owner_m = 0;
    acc_cyc = 0;
    presenting[0] = 1'b0;
    presenting[1] = 1'b0;
    cur[0] = '0;
    cur[1] = '0;
    q0.delete();
    q1.delete();
    grants.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    model_reset();
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    int g_exp;
    bit acc_now, hs_now;
    logic [1:0] exp_rdy, exp_rv;
    @(negedge clk);
    exp_rdy = 2'b00;
    exp_rv  = 2'b00;
    acc_now = 1'b0;
    hs_now  = 1'b0;
    g_exp   = -1;
    if (!busy) begin
      g_exp = pick(req_valid[0], req_valid[1], last_m);
      if (g_exp >= 0) begin
        exp_rdy[g_exp] = 1'b1;
        acc_now = 1'b1;
      end
    end else if (cyc >= acc_cyc + 1) begin
      exp_rv[owner_m] = 1'b1;
      hs_now = rsp_ready[owner_m];
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv != 2'b00) begin
      chk("rsp_result", 32'(rsp_result), 32'(exp_res));
      chk("rsp_onz", 32'(rsp_onz), 32'(exp_onz));
    end
    chk("ovf_count", 32'(ovf_count), 32'(ovf_exp()));
    if ((req_ready & req_valid) != 2'b00) grants.push_back(req_ready[1] ? 1 : 0);
    @(posedge clk);
    cyc++;
    if (busy && cyc == acc_cyc + 1 && exp_ovf && ovf_m < 255) ovf_m++;
    if (hs_now) begin
      busy = 1'b0;
      last_m = owner_m;
    end
    if (acc_now) begin
      busy = 1'b1;
      owner_m = g_exp;
      acc_cyc = cyc;
      {exp_ovf, exp_onz[1:0], exp_res} = alu_fn(cur[g_exp].op, cur[g_exp].a, cur[g_exp].b);
      exp_onz[2] = exp_ovf;
      presenting[g_exp] = 1'b0;
    end
    #1;
    drive();
  endtask

  task automatic run(input string tag, input int max_cycles);
    bit drained;
    drive();
    drained = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && !presenting[0] && !presenting[1] && !busy) begin
        drained = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_drained"}, 32'(drained), 32'd1);
  endtask

  initial begin
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    {req0_op, req0_a, req0_b} = '0;
    {req1_op, req1_a, req1_b} = '0;
    cyc = 0;
    gaps = 0;
    rsp_mode = 0;
    stall_cnt = 0;
    exp_ovf = 1'b0;
    exp_res = '0;
    exp_onz = '0;
    model_reset();

    // Single requester: 7+1 overflows to 1000 with O and N set.
    do_reset();
    q0.push_back('{op: 3'd0, a: 4'd7, b: 4'd1});
    run("single", 20);
    chk("single_grant", 32'(grants.size() == 1 && grants[0] == 0), 32'd1);

    // Both valid right after reset: r0 (AND) first, then r1 (XOR).
    do_reset();
    q0.push_back('{op: 3'd2, a: 4'd5, b: 4'd3});
    q1.push_back('{op: 3'd4, a: 4'd5, b: 4'd3});
    run("tie", 30);
    chk("tie_count", 32'(grants.size()), 32'd2);
    chk("tie_first", 32'(grants[0]), 32'd0);
    chk("tie_second", 32'(grants[1]), 32'd1);

    // Continuous contention: six ops strictly alternate.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{op: 3'($urandom_range(7, 0)), a: 4'($urandom), b: 4'($urandom)});
      q1.push_back('{op: 3'($urandom_range(7, 0)), a: 4'($urandom), b: 4'($urandom)});
    end
    run("alt", 60);
    chk("alt_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++) begin
      chk($sformatf("alt_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    end

    // Response stalled 5 cycles with r1 waiting; r1 follows after the handshake.
    do_reset();
    rsp_mode = 2;
    stall_cnt = 5;
    q0.push_back('{op: 3'd1, a: 4'd3, b: 4'd3});
    q1.push_back('{op: 3'd6, a: 4'd9, b: 4'd2});
    run("stall", 40);
    chk("stall_used", 32'(stall_cnt), 32'd0);
    chk("stall_order", 32'(grants.size() == 2 && grants[0] == 0 && grants[1] == 1), 32'd1);
    rsp_mode = 0;

    // Reset during EXEC discards the op and clears everything.
    do_reset();
    q0.push_back('{op: 3'd7, a: 4'd6, b: 4'd5});
    drive();
    for (int i = 0; i < 5 && !busy; i++) step();
    chk("rstx_accepted", 32'(busy), 32'd1);
    rst_n = 1'b0;
    model_reset();
    req_valid = 2'b00;
    #1;
    chk_all_zero("rstx");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rstx_no_grant", 32'(grants.size()), 32'd0);

    // Three overflowing ADDs then a plain SUB.
    do_reset();
    q0.push_back('{op: 3'd0, a: 4'd7, b: 4'd1});
    q0.push_back('{op: 3'd0, a: 4'd7, b: 4'd7});
    q0.push_back('{op: 3'd0, a: 4'd8, b: 4'd8});
    q0.push_back('{op: 3'd1, a: 4'd3, b: 4'd1});
    run("ovf", 40);
`ifdef ALU_SHARE_OVF_CNT_EN
    chk("ovf_final", 32'(ovf_count), 32'd3);
`else
    chk("ovf_final", 32'(ovf_count), 32'd0);
`endif

    // Random traffic with gaps and random response backpressure.
    do_reset();
    gaps = 1;
    rsp_mode = 1;
    for (int i = 0; i < 25; i++) begin
      q0.push_back('{op: 3'($urandom_range(7, 0)), a: 4'($urandom), b: 4'($urandom)});
      q1.push_back('{op: 3'($urandom_range(7, 0)), a: 4'($urandom), b: 4'($urandom)});
    end
    run("rand", 2000);
    chk("rand_count", 32'(grants.size()), 32'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
